// File: rtl/engine_alu_ops_result_buffer_pkg.sv
// Shared types and constants for the ALU engine result buffer.
//   EnginePacketData            - kernel result packet (passed through unmodified)
//   EngineAluResultBufferStatus - occupancy/overflow/counter bundle for the CSR path
package engine_alu_ops_result_buffer_pkg;

  localparam int unsigned ENGINE_ALU_RESULT_BUFFER_DEPTH = 16;
  localparam int unsigned ENGINE_ALU_KERNEL_LATENCY      = 3;
  localparam int unsigned ENGINE_ALU_RESULT_BUFFER_CNT_W = 32;
  localparam int unsigned ENGINE_ALU_RESULT_BUFFER_OCC_W =
    $clog2(ENGINE_ALU_RESULT_BUFFER_DEPTH) + 1;

  typedef struct packed {
    logic [3:0][31:0] field;
  } EnginePacketData;

  typedef struct packed {
    logic [ENGINE_ALU_RESULT_BUFFER_OCC_W-1:0] occupancy;
    logic                                      overflow;
    logic [ENGINE_ALU_RESULT_BUFFER_CNT_W-1:0] accepted_count;
  } EngineAluResultBufferStatus;

endpackage

// File: rtl/engine_alu_ops_result_fifo_core.sv
// Generic register FIFO with first-word fall-through read port.
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   clear_i         - synchronous flush, overrides push/pop
//   push_i, wdata_i - write strobe and data (caller guarantees not full unless popping)
//   pop_i           - read strobe (caller guarantees not empty)
//   rdata_o         - head entry, '0 while empty
//   occupancy_o     - entry count; empty_o / full_o derived from it
module engine_alu_ops_result_fifo_core #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly AW bits so they wrap at DEPTH without compare logic.
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; reads are masked while empty.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign occupancy_o = count_q;
  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == (AW+1)'(DEPTH));
  assign rdata_o     = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/engine_alu_ops_result_buffer.sv
// Captures every flagged ALU-kernel result into a FIFO and presents it on a
// valid/ready interface. A registered early stall throttles the kernel so that
// packets already in its pipeline always find space.
//   ap_clk, ap_rst_n     - clock, asynchronous active-low reset
//   clear                - synchronous flush (priority over push/pop)
//   in_valid, in_data    - kernel result flag and packet (no backpressure)
//   out_valid, out_data  - head entry, first-word fall-through
//   out_ready            - consumer takes the head this cycle
//   upstream_stall       - registered; occupancy has reached DEPTH-STALL_SLACK
//   occupancy            - entry count
//   overflow             - sticky; a packet arrived while full and not popping
//   accepted_count       - packets written since reset/clear, wrapping
module engine_alu_ops_result_buffer
  import engine_alu_ops_result_buffer_pkg::*;
#(
  parameter int unsigned DEPTH       = ENGINE_ALU_RESULT_BUFFER_DEPTH,
  parameter int unsigned STALL_SLACK = ENGINE_ALU_KERNEL_LATENCY + 1,
  parameter int unsigned CNT_W       = ENGINE_ALU_RESULT_BUFFER_CNT_W
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  input  EnginePacketData        in_data,
  output logic                   out_valid,
  output EnginePacketData        out_data,
  input  logic                   out_ready,
  output logic                   upstream_stall,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflow,
  output logic [CNT_W-1:0]       accepted_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 8");
  end
  if (STALL_SLACK >= DEPTH) begin : g_bad_slack
    $error("STALL_SLACK must be smaller than DEPTH");
  end

  logic            fifo_empty, fifo_full;
  logic            push, pop;
  logic [AW:0]     occ_q;
  logic [AW:0]     occ_next;
  logic            stall_q, stall_d;
  logic            overflow_q, overflow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // clear masks both handshakes so nothing is stored or counted that cycle.
  assign pop  = !fifo_empty && out_ready && !clear;
  assign push = in_valid && (!fifo_full || pop) && !clear;

  engine_alu_ops_result_fifo_core #(
    .DEPTH (DEPTH),
    .W     ($bits(EnginePacketData))
  ) u_fifo (
    .clk_i       (ap_clk),
    .rst_ni      (ap_rst_n),
    .clear_i     (clear),
    .push_i      (push),
    .wdata_i     (in_data),
    .pop_i       (pop),
    .rdata_o     (out_data),
    .occupancy_o (occ_q),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign occ_next = occ_q + (AW+1)'(push) - (AW+1)'(pop);

  always_comb begin
    stall_d    = stall_q;
    overflow_d = overflow_q;
    cnt_d      = cnt_q;
    if (clear) begin
      stall_d    = 1'b0;
      overflow_d = 1'b0;
      cnt_d      = '0;
    end else begin
      stall_d = (occ_next >= (AW+1)'(DEPTH - STALL_SLACK));
      if (in_valid && !push) overflow_d = 1'b1;
      if (push)              cnt_d      = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid      = !fifo_empty;
  assign occupancy      = occ_q;
  assign upstream_stall = stall_q;
  assign overflow       = overflow_q;
  assign accepted_count = cnt_q;

endmodule

// File: tb/tb_engine_alu_ops_result_buffer.sv
module tb_engine_alu_ops_result_buffer;
  import engine_alu_ops_result_buffer_pkg::*;

  logic            ap_clk = 1'b0;
  logic            ap_rst_n;
  logic            clear;
  logic            in_valid;
  EnginePacketData in_data;
  logic            out_valid;
  EnginePacketData out_data;
  logic            out_ready;
  logic            upstream_stall;
  logic [4:0]      occupancy;
  logic            overflow;
  logic [31:0]     accepted_count;

  int checks   = 0;
  int failures = 0;

  engine_alu_ops_result_buffer #(
    .DEPTH       (16),
    .STALL_SLACK (4),
    .CNT_W       (32)
  ) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .clear          (clear),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .upstream_stall (upstream_stall),
    .occupancy      (occupancy),
    .overflow       (overflow),
    .accepted_count (accepted_count)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic EnginePacketData pkt(input logic [31:0] v);
    EnginePacketData p;
    p = '0;
    p.field[0] = v;
    p.field[1] = ~v;
    p.field[3] = 32'hA5A5_0000 ^ v;
    return p;
  endfunction

  // One clock; outputs are then sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    clear = 1'b0;
  endtask

  task automatic fill(input int n, input int first);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = pkt(32'(first + i));
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 5'd0 || upstream_stall !== 1'b0 ||
        overflow !== 1'b0 || accepted_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%b occ=%0d stall=%b ovf=%b cnt=%0d expected 0/0/0/0/0",
               out_valid, occupancy, upstream_stall, overflow, accepted_count);
    end
    checks++;
    if (out_data !== EnginePacketData'('0)) begin
      failures++;
      $display("FAIL reset_data: got %h expected 0", out_data);
    end
    ap_rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill_threshold();
    do_clear();
    fill(1, 1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== pkt(32'd1)) begin
      failures++;
      $display("FAIL first_word_latency: valid=%b data=%h expected 1/%h", out_valid, out_data, pkt(32'd1));
    end
    fill(10, 2);
    checks++;
    if (occupancy !== 5'd11 || upstream_stall !== 1'b0) begin
      failures++;
      $display("FAIL below_threshold: occ=%0d stall=%b expected 11/0", occupancy, upstream_stall);
    end
    fill(1, 12);
    checks++;
    if (occupancy !== 5'd12 || upstream_stall !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL at_threshold: occ=%0d stall=%b ovf=%b expected 12/1/0", occupancy, upstream_stall, overflow);
    end
  endtask

  task automatic test_fill_drain();
    do_clear();
    fill(16, 1);
    checks++;
    if (occupancy !== 5'd16 || accepted_count !== 32'd16 || upstream_stall !== 1'b1) begin
      failures++;
      $display("FAIL full_state: occ=%0d cnt=%0d stall=%b expected 16/16/1", occupancy, accepted_count, upstream_stall);
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== pkt(32'(k))) begin
        failures++;
        $display("FAIL drain_order[%0d]: valid=%b field0=%h expected 1/%h", k, out_valid, out_data.field[0], k);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 5'd0 || accepted_count !== 32'd16 || upstream_stall !== 1'b0) begin
      failures++;
      $display("FAIL drained: valid=%b occ=%0d cnt=%0d stall=%b expected 0/0/16/0",
               out_valid, occupancy, accepted_count, upstream_stall);
    end
  endtask

  task automatic test_overflow();
    do_clear();
    fill(16, 1);
    in_valid = 1'b1; in_data = pkt(32'hDEAD);
    step();
    in_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1 || occupancy !== 5'd16 || accepted_count !== 32'd16) begin
      failures++;
      $display("FAIL overflow_state: ovf=%b occ=%0d cnt=%0d expected 1/16/16", overflow, occupancy, accepted_count);
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      checks++;
      if (out_data !== pkt(32'(k)) || out_data.field[0] === 32'hDEAD) begin
        failures++;
        $display("FAIL overflow_drain[%0d]: field0=%h expected %h", k, out_data.field[0], k);
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (overflow !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL overflow_sticky: ovf=%b valid=%b expected 1/0", overflow, out_valid);
    end
  endtask

  task automatic test_full_push_pop();
    do_clear();
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL clear_overflow: ovf=%b expected 0", overflow);
    end
    fill(16, 1);
    in_valid = 1'b1; in_data = pkt(32'h77); out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 5'd16 || overflow !== 1'b0 || accepted_count !== 32'd17) begin
      failures++;
      $display("FAIL full_push_pop: occ=%0d ovf=%b cnt=%0d expected 16/0/17", occupancy, overflow, accepted_count);
    end
    for (int k = 2; k <= 17; k++) begin
      logic [31:0] e;
      e = (k == 17) ? 32'h77 : 32'(k);
      checks++;
      if (out_valid !== 1'b1 || out_data !== pkt(e)) begin
        failures++;
        $display("FAIL full_pp_drain[%0d]: field0=%h expected %h", k, out_data.field[0], e);
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_clear();
    do_clear();
    fill(5, 40);
    checks++;
    if (occupancy !== 5'd5) begin
      failures++;
      $display("FAIL clear_pre_occ: occ=%0d expected 5", occupancy);
    end
    clear = 1'b1; in_valid = 1'b1; in_data = pkt(32'h99); out_ready = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (occupancy !== 5'd0 || out_valid !== 1'b0 || accepted_count !== 32'd0 || upstream_stall !== 1'b0) begin
      failures++;
      $display("FAIL clear_state: occ=%0d valid=%b cnt=%0d stall=%b expected 0/0/0/0",
               occupancy, out_valid, accepted_count, upstream_stall);
    end
    fill(1, 32'h55);
    checks++;
    if (occupancy !== 5'd1 || out_data !== pkt(32'h55)) begin
      failures++;
      $display("FAIL clear_not_stored: occ=%0d field0=%h expected 1/55", occupancy, out_data.field[0]);
    end
  endtask

  task automatic test_back_to_back();
    // Streaming push+pop across the pointer wrap, starting from one entry.
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      logic [31:0] e;
      e = (k == 0) ? 32'h55 : 32'(100 + k - 1);
      checks++;
      if (out_data !== pkt(e) || occupancy !== 5'd1) begin
        failures++;
        $display("FAIL stream[%0d]: field0=%h occ=%0d expected %h/1", k, out_data.field[0], occupancy, e);
      end
      in_valid = 1'b1; in_data = pkt(32'(100 + k));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_clear();
    fill(7, 1);
    checks++;
    if (occupancy !== 5'd7) begin
      failures++;
      $display("FAIL areset_pre_occ: occ=%0d expected 7", occupancy);
    end
    out_ready = 1'b1;
    #3;
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 5'd0 || accepted_count !== 32'd0) begin
      failures++;
      $display("FAIL areset_immediate: valid=%b occ=%0d cnt=%0d expected 0/0/0", out_valid, occupancy, accepted_count);
    end
    out_ready = 1'b0;
    #2;
    ap_rst_n = 1'b1;
    step();
    fill(1, 32'h42);
    checks++;
    if (out_data !== pkt(32'h42) || occupancy !== 5'd1 || accepted_count !== 32'd1) begin
      failures++;
      $display("FAIL areset_resume: field0=%h occ=%0d cnt=%0d expected 42/1/1", out_data.field[0], occupancy, accepted_count);
    end
  endtask

  initial begin
    test_reset();
    test_fill_threshold();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_clear();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
